pipe_control: RTL
=================

# pipe_control

Pipelined main-control unit for the 5-stage MIPS datapath. It decodes the ID-stage opcode into the control bundle and carries each field through ID/EX, EX/MEM and MEM/WB registers, so each stage reads its own control outputs. It also performs load-use hazard detection (stall plus bubble insertion), squashes wrong-path instructions on a taken branch, separates bne from beq, flags illegal opcodes, and counts stall cycles.

## Interface
- OPCODE_W, 6, opcode field width
- REG_W, 5, register-specifier width
- ALUOP_W, 3, ALUOp width (≥3; codes zero-extended)
- CNT_W, 16, stall-counter width
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all pipeline control state and the counter
- id_valid  in  1  IF/ID holds a real instruction
- opcode  in  OPCODE_W  IF/ID opcode
- id_rs, id_rt  in  REG_W  IF/ID source specifiers
- flush  in  1  taken branch resolved in MEM this cycle
- stall  out  1  hold PC and IF/ID (combinational)
- id_illegal  out  1  id_valid and opcode not decoded (combinational)
- ex_RegDest, ex_ALUSrc  out  1  EX-stage controls
- ex_ALUOp  out  ALUOP_W  EX-stage ALU operation class
- mem_Branch, mem_BranchNe, mem_MemRead, mem_MemWrite  out  1  MEM-stage controls
- wb_MemtoReg, wb_RegWrite  out  1  WB-stage controls
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Decode (opcode hex; unlisted fields 0):
  - 00 R-type: RegDest=1, RegWrite=1, ALUOp=010.
  - 08 addi: ALUSrc=1, RegWrite=1, ALUOp=100.
  - 0C andi: ALUSrc=1, RegWrite=1, ALUOp=101.
  - 0D ori: ALUSrc=1, RegWrite=1, ALUOp=111.
  - 23 lw: ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, ALUOp=000.
  - 2B sw: ALUSrc=1, MemWrite=1, ALUOp=000.
  - 04 beq: Branch=1, ALUOp=001.
  - 05 bne: Branch=1, BranchNe=1, ALUOp=001.
- Any other opcode: all fields 0 (bubble). id_illegal=1 when id_valid=1.
- A bubble is all control fields 0 with valid=0.
- ID/EX captures:
  - the decoded bundle, valid=id_valid, and ex_rt=id_rt;
  - a bubble instead when id_valid=0, stall=1 or flush=1.
- EX/MEM captures ID/EX fields, or a bubble when flush=1.
- MEM/WB always captures EX/MEM fields.
- Load-use hazard: ex_load = ID/EX valid & MemRead.
- stall = id_valid & ex_load & (ex_rt≠0) & (ex_rt==id_rs | ex_rt==id_rt) & ~flush.
- For a stall the lw completes normally and the dependent instruction re-decodes next cycle, when the hazard is gone.
- flush has priority over stall. The branch in MEM still advances to WB, where it is harmless (no RegWrite).
- stall_cnt increments each cycle stall=1 and saturates at 2^CNT_W−1 with no wrap.

## Timing
- Reset (synchronous): all ex_/mem_/wb_ outputs 0, all valid bits 0, stall 0, stall_cnt 0.
- Reset asserted mid-operation discards every in-flight instruction at that edge.
- Latency: opcode presented in cycle n gives ex_* in n+1, mem_* in n+2 and wb_* in n+3.
- stall and id_illegal are combinational from current inputs and ID/EX state, so they are valid in the same cycle.
- Stall lasts exactly one cycle per lw→use pair. Back-to-back dependent loads each stall once.
- When flush and stall are both asserted: flush wins, stall reads 0, and stall_cnt does not increment.
- Illegal opcodes propagate as bubbles and never assert MemWrite or RegWrite.

## Test plan
- **Decode and propagation.** Apply reset, then 00,08,0C,0D,23,2B,04,05 on consecutive cycles with id_valid=1. Each bundle must appear per the decode list with ex_* at +1, mem_* at +2, wb_* at +3. bne must give mem_BranchNe=1; beq must give 0.
- **Load-use stall.** lw with rt=5, next instruction R-type with rs=5. stall=1 for one cycle and the following ex_* are all 0. On the next cycle the R-type decodes with stall=0, and stall_cnt=1. Repeat with rt=0: there must be no stall.
- **Flush squash.** Stream of R-types, then flush=1 for one cycle. At the next edge ID/EX and EX/MEM are bubbles, so ex_* and mem_* are 0. wb_RegWrite follows the pre-flush MEM contents.
- **Flush during hazard.** lw rt=3 followed by a use of r3, with flush=1 in the same cycle. stall=0, stall_cnt is unchanged, and the ID/EX result is a bubble.
- **Illegal and reset.** Opcode 3F with id_valid=1 gives id_illegal=1 and all-zero bundles downstream. Asserting reset mid-stream zeroes every output and stall_cnt on the next edge.
- **Counter saturation.** With CNT_W=2, force 5 hazard stalls. stall_cnt must read 3 and hold there.

Source files
------------

// File: rtl/pipe_control.sv
// -----------------------------------------------------------------------------
// pipe_control
//
// Pipelined main-control unit for a 5-stage MIPS datapath. The ID-stage
// opcode is decoded into a control bundle that travels through the ID/EX,
// EX/MEM and MEM/WB registers, so each stage drives its own control outputs.
// The unit also detects load-use hazards (stall plus bubble insertion),
// squashes wrong-path instructions on a taken branch, flags illegal opcodes
// and keeps a saturating count of stall cycles.
//
// Ports
//   clk, reset        single clock; synchronous active-high reset
//   id_valid          IF/ID holds a real instruction
//   opcode            IF/ID opcode field
//   id_rs, id_rt      IF/ID source register specifiers
//   flush             taken branch resolved in MEM this cycle
//   stall             hold PC and IF/ID (combinational)
//   id_illegal        valid IF/ID instruction with an undecoded opcode
//   ex_*              EX-stage controls   (opcode latency +1)
//   mem_*             MEM-stage controls  (opcode latency +2)
//   wb_*              WB-stage controls   (opcode latency +3)
//   stall_cnt         saturating count of stall cycles
// -----------------------------------------------------------------------------
module pipe_control #(
  parameter int OPCODE_W = 6,
  parameter int REG_W    = 5,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                flush,
  output logic                stall,
  output logic                id_illegal,
  output logic                ex_RegDest,
  output logic                ex_ALUSrc,
  output logic [ALUOP_W-1:0]  ex_ALUOp,
  output logic                mem_Branch,
  output logic                mem_BranchNe,
  output logic                mem_MemRead,
  output logic                mem_MemWrite,
  output logic                wb_MemtoReg,
  output logic                wb_RegWrite,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'h00);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'h08);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'h0C);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'h0D);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'h23);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'h2B);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'h04);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'h05);

  // Control fields grouped by the stage that consumes them; each pipeline
  // register only carries the groups still needed downstream.
  typedef struct packed {
    logic               reg_dest;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic branch_ne;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_t;

  ctrl_t      id_ctrl;
  logic       id_legal;

  ctrl_t      idex_ctrl;
  logic       idex_valid;
  logic [REG_W-1:0] idex_rt;

  mem_ctrl_t  exmem_mem;
  wb_ctrl_t   exmem_wb;
  wb_ctrl_t   memwb_wb;

  logic       ex_load;
  logic       id_bubble;

  // NOTE: every field gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    id_ctrl  = '0;
    id_legal = 1'b1;
    unique case (opcode)
      OP_RTYPE: begin
        id_ctrl.ex.reg_dest  = 1'b1;
        id_ctrl.wb.reg_write = 1'b1;
        id_ctrl.ex.alu_op    = ALUOP_W'(3'b010);
      end
      OP_ADDI: begin
        id_ctrl.ex.alu_src   = 1'b1;
        id_ctrl.wb.reg_write = 1'b1;
        id_ctrl.ex.alu_op    = ALUOP_W'(3'b100);
      end
      OP_ANDI: begin
        id_ctrl.ex.alu_src   = 1'b1;
        id_ctrl.wb.reg_write = 1'b1;
        id_ctrl.ex.alu_op    = ALUOP_W'(3'b101);
      end
      OP_ORI: begin
        id_ctrl.ex.alu_src   = 1'b1;
        id_ctrl.wb.reg_write = 1'b1;
        id_ctrl.ex.alu_op    = ALUOP_W'(3'b111);
      end
      OP_LW: begin
        id_ctrl.ex.alu_src    = 1'b1;
        id_ctrl.mem.mem_read  = 1'b1;
        id_ctrl.wb.mem_to_reg = 1'b1;
        id_ctrl.wb.reg_write  = 1'b1;
        id_ctrl.ex.alu_op     = ALUOP_W'(3'b000);
      end
      OP_SW: begin
        id_ctrl.ex.alu_src   = 1'b1;
        id_ctrl.mem.mem_write = 1'b1;
        id_ctrl.ex.alu_op    = ALUOP_W'(3'b000);
      end
      OP_BEQ: begin
        id_ctrl.mem.branch = 1'b1;
        id_ctrl.ex.alu_op  = ALUOP_W'(3'b001);
      end
      OP_BNE: begin
        id_ctrl.mem.branch    = 1'b1;
        id_ctrl.mem.branch_ne = 1'b1;
        id_ctrl.ex.alu_op     = ALUOP_W'(3'b001);
      end
      default: id_legal = 1'b0;  // undecoded opcodes travel as all-zero bubbles
    endcase
  end

  assign id_illegal = id_valid & ~id_legal;

  // A load in EX whose destination is read by the instruction in ID must hold
  // that instruction one cycle. r0 never creates a dependence, and a flush
  // squashes the dependent instruction anyway, so it overrides the stall.
  assign ex_load = idex_valid & idex_ctrl.mem.mem_read;
  assign stall   = id_valid & ex_load & (idex_rt != '0) &
                   ((idex_rt == id_rs) | (idex_rt == id_rt)) & ~flush;

  assign id_bubble = ~id_valid | stall | flush;

  // NOTE: pipeline state uses non-blocking assignments so every register
  // samples the previous-cycle values of the others at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: reset is synchronous; every in-flight instruction is dropped
      // at the edge where it is seen.
      idex_ctrl  <= '0;
      idex_valid <= 1'b0;
      idex_rt    <= '0;
      exmem_mem  <= '0;
      exmem_wb   <= '0;
      memwb_wb   <= '0;
      stall_cnt  <= '0;
    end else begin
      if (id_bubble) begin
        idex_ctrl  <= '0;
        idex_valid <= 1'b0;
        idex_rt    <= '0;
      end else begin
        idex_ctrl  <= id_ctrl;
        idex_valid <= 1'b1;
        idex_rt    <= id_rt;
      end

      // The instruction in EX is on the wrong path when the branch in MEM
      // resolves taken; the branch itself still retires harmlessly in WB.
      if (flush) begin
        exmem_mem <= '0;
        exmem_wb  <= '0;
      end else begin
        exmem_mem <= idex_ctrl.mem;
        exmem_wb  <= idex_ctrl.wb;
      end

      memwb_wb <= exmem_wb;

      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_RegDest   = idex_ctrl.ex.reg_dest;
  assign ex_ALUSrc    = idex_ctrl.ex.alu_src;
  assign ex_ALUOp     = idex_ctrl.ex.alu_op;
  assign mem_Branch   = exmem_mem.branch;
  assign mem_BranchNe = exmem_mem.branch_ne;
  assign mem_MemRead  = exmem_mem.mem_read;
  assign mem_MemWrite = exmem_mem.mem_write;
  assign wb_MemtoReg  = memwb_wb.mem_to_reg;
  assign wb_RegWrite  = memwb_wb.reg_write;

endmodule
